// File: rtl/chroma_composite_gen_pkg.sv
// Shared constants, types and helpers for the composite chroma generator.
// Covers the sine-table encoding, the sideband record and the output clamp.
package chroma_composite_gen_pkg;

  localparam int ADDR_WIDTH  = 12;
  localparam int DATA_WIDTH  = 9;
  localparam int ACC_WIDTH   = 24;
  localparam int OUT_WIDTH   = 10;
  localparam int PHASE_WIDTH = 8;
  localparam int AMP_WIDTH   = 3;
  localparam int LUMA_WIDTH  = 6;
  localparam int SUM_WIDTH   = OUT_WIDTH + 2;

  localparam logic [OUT_WIDTH-1:0]        BLANK_LEVEL_DEF = 10'd128;
  localparam logic [AMP_WIDTH-1:0]        AMP_NONE        = 3'd0;
  localparam logic [DATA_WIDTH-1:0]       SINE_CENTRE     = 9'd256;
  localparam logic signed [SUM_WIDTH-1:0] OUT_MAX         = 12'sd1023;

  typedef struct packed {
    logic [LUMA_WIDTH-1:0] luma;
    logic                  blank;
    logic                  sync;
    logic                  cen;
  } side_t;

  localparam side_t SIDE_RESET = '{luma: 6'd0, blank: 1'b0, sync: 1'b0, cen: 1'b0};

  // Amplitude code k selects table k-1; code 0 parks the address on table 0.
  function automatic logic [AMP_WIDTH-1:0] table_sel(input logic [AMP_WIDTH-1:0] amp);
    logic [AMP_WIDTH-1:0] sel;
    if (amp == AMP_NONE) begin
      sel = 3'd0;
    end else begin
      sel = amp - 3'd1;
    end
    return sel;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] clamp_out(input logic signed [SUM_WIDTH-1:0] s);
    logic [OUT_WIDTH-1:0] res;
    if (s < 12'sd0) begin
      res = {OUT_WIDTH{1'b0}};
    end else if (s > OUT_MAX) begin
      res = {OUT_WIDTH{1'b1}};
    end else begin
      res = s[OUT_WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/chroma_composite_gen_if.sv
// Pixel, tuning, sine-ROM and composite-output signals of the chroma generator.
interface chroma_composite_gen_if;
  import chroma_composite_gen_pkg::*;

  logic [ACC_WIDTH-1:0]   phase_inc;
  logic                   phase_reset;
  logic [LUMA_WIDTH-1:0]  luma;
  logic [PHASE_WIDTH-1:0] chroma_phase;
  logic [AMP_WIDTH-1:0]   chroma_amp;
  logic                   burst;
  logic [PHASE_WIDTH-1:0] burst_phase;
  logic [AMP_WIDTH-1:0]   burst_amp;
  logic                   blank;
  logic                   sync;
  logic [ADDR_WIDTH-1:0]  rom_addr;
  logic [DATA_WIDTH-1:0]  rom_dout;
  logic [OUT_WIDTH-1:0]   comp_out;
  logic                   comp_valid;

  modport master (
    output phase_inc, phase_reset, luma, chroma_phase, chroma_amp,
           burst, burst_phase, burst_amp, blank, sync, rom_dout,
    input  rom_addr, comp_out, comp_valid
  );

  modport slave (
    input  phase_inc, phase_reset, luma, chroma_phase, chroma_amp,
           burst, burst_phase, burst_amp, blank, sync, rom_dout,
    output rom_addr, comp_out, comp_valid
  );

endinterface

// File: rtl/chroma_composite_gen_subcarrier_nco.sv
// Colour-subcarrier phase accumulator; phase_reset wins over the increment.
module chroma_composite_gen_subcarrier_nco
  import chroma_composite_gen_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ACC_WIDTH-1:0]   i_phase_inc,
  input  logic                   i_phase_reset,
  output logic [PHASE_WIDTH-1:0] o_phase
);

  logic [ACC_WIDTH-1:0] r_acc;

  // Accumulator with natural modulo-2^ACC_WIDTH wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= {ACC_WIDTH{1'b0}};
    end else if (i_phase_reset) begin
      r_acc <= {ACC_WIDTH{1'b0}};
    end else begin
      r_acc <= r_acc + i_phase_inc;
    end
  end

  assign o_phase = r_acc[ACC_WIDTH-1 -: PHASE_WIDTH];

endmodule

// File: rtl/chroma_composite_gen.sv
// Composite chroma stage: sine-ROM addressing, sideband re-alignment across the
// ROM latency, and luma + chroma mixing into a clamped composite sample.
module chroma_composite_gen
  import chroma_composite_gen_pkg::*;
#(
  parameter logic [OUT_WIDTH-1:0] BLANK_LEVEL = BLANK_LEVEL_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chroma_composite_gen_if.slave bus
);

  logic [PHASE_WIDTH-1:0]      w_acc8;
  logic [PHASE_WIDTH-1:0]      w_ph;
  logic [PHASE_WIDTH-1:0]      w_p8;
  logic [AMP_WIDTH-1:0]        w_amp;
  side_t                       w_side0;
  side_t                       r_side1;
  side_t                       r_side2;
  logic [ADDR_WIDTH-1:0]       r_rom_addr;
  logic signed [SUM_WIDTH-1:0] w_chroma;
  logic signed [SUM_WIDTH-1:0] w_y;
  logic signed [SUM_WIDTH-1:0] w_sum;
  logic [OUT_WIDTH-1:0]        w_mix;
  logic [OUT_WIDTH-1:0]        r_comp_out;
  logic [2:0]                  r_fill;

  chroma_composite_gen_subcarrier_nco u_nco (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_phase_inc   (bus.phase_inc),
    .i_phase_reset (bus.phase_reset),
    .o_phase       (w_acc8)
  );

  // S0: burst substitutes its own phase/amplitude before the phase offset is added.
  always_comb begin
    w_ph  = bus.chroma_phase;
    w_amp = bus.chroma_amp;
    if (bus.burst) begin
      w_ph  = bus.burst_phase;
      w_amp = bus.burst_amp;
    end else begin
      w_ph  = bus.chroma_phase;
      w_amp = bus.chroma_amp;
    end
    w_p8          = w_acc8 + w_ph;
    w_side0.luma  = bus.luma;
    w_side0.blank = bus.blank;
    w_side0.sync  = bus.sync;
    w_side0.cen   = (w_amp != AMP_NONE);
  end

  // ROM address register and the two sideband stages that track the ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= {ADDR_WIDTH{1'b0}};
      r_side1    <= SIDE_RESET;
      r_side2    <= SIDE_RESET;
    end else begin
      r_rom_addr <= {1'b0, table_sel(w_amp), w_p8};
      r_side1    <= w_side0;
      r_side2    <= r_side1;
    end
  end

  // S2 mixer: signed chroma about the sine centre plus the luma pedestal.
  always_comb begin
    w_chroma = 12'sd0;
    w_y      = $signed({2'b00, BLANK_LEVEL});
    if (r_side2.cen) begin
      w_chroma = $signed({3'b000, bus.rom_dout}) - $signed({3'b000, SINE_CENTRE});
    end else begin
      w_chroma = 12'sd0;
    end
    if (r_side2.blank) begin
      w_y = $signed({2'b00, BLANK_LEVEL});
    end else begin
      w_y = $signed({2'b00, BLANK_LEVEL}) + $signed({3'b000, r_side2.luma, 3'b000});
    end
    w_sum = w_y + w_chroma;
    w_mix = clamp_out(w_sum);
  end

  // Output register; sync forces the sync tip regardless of the mix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_comp_out <= {OUT_WIDTH{1'b0}};
    end else if (r_side2.sync) begin
      r_comp_out <= {OUT_WIDTH{1'b0}};
    end else begin
      r_comp_out <= w_mix;
    end
  end

  // Pipeline-fill tracker: a one walks in so valid rises on the third clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= 3'b000;
    end else begin
      r_fill <= {r_fill[1:0], 1'b1};
    end
  end

  assign bus.rom_addr   = r_rom_addr;
  assign bus.comp_out   = r_comp_out;
  assign bus.comp_valid = r_fill[2];

endmodule

// File: tb/tb_chroma_composite_gen.sv
// Directed bench: three instances (blank level 128, 0 and 600) share one stimulus
// and each gets a 1-cycle sine-ROM model that is either addr[7:0]+128 or a constant.
module tb_chroma_composite_gen;
  import chroma_composite_gen_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [ACC_WIDTH-1:0]   phase_inc = 24'd0;
  logic                   phase_reset = 1'b0;
  logic [LUMA_WIDTH-1:0]  luma = 6'd0;
  logic [PHASE_WIDTH-1:0] chroma_phase = 8'd0;
  logic [AMP_WIDTH-1:0]   chroma_amp = 3'd0;
  logic                   burst = 1'b0;
  logic [PHASE_WIDTH-1:0] burst_phase = 8'd0;
  logic [AMP_WIDTH-1:0]   burst_amp = 3'd0;
  logic                   blank = 1'b0;
  logic                   sync = 1'b0;
  logic                   rom_mode = 1'b0;
  logic [DATA_WIDTH-1:0]  rom_const = 9'd0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    chroma_composite_gen_if u_bus ();

    assign u_bus.phase_inc    = phase_inc;
    assign u_bus.phase_reset  = phase_reset;
    assign u_bus.luma         = luma;
    assign u_bus.chroma_phase = chroma_phase;
    assign u_bus.chroma_amp   = chroma_amp;
    assign u_bus.burst        = burst;
    assign u_bus.burst_phase  = burst_phase;
    assign u_bus.burst_amp    = burst_amp;
    assign u_bus.blank        = blank;
    assign u_bus.sync         = sync;

    // Sine ROM stand-in with one clock of read latency.
    always @(posedge clk) begin
      if (rom_mode) u_bus.rom_dout <= rom_const;
      else          u_bus.rom_dout <= {1'b0, u_bus.rom_addr[7:0]} + 9'd128;
    end

    chroma_composite_gen #(
      .BLANK_LEVEL((g == 0) ? 10'd128 : ((g == 1) ? 10'd0 : 10'd600))
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_bus.slave)
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(2);
    check_eq("rst_addr",  32'(g_dut[0].u_bus.rom_addr),   32'h000);
    check_eq("rst_out",   32'(g_dut[0].u_bus.comp_out),   32'd0);
    check_eq("rst_valid", 32'(g_dut[0].u_bus.comp_valid), 32'd0);
    rst_n = 1'b1;
    step(2);
    check_eq("valid_clk2", 32'(g_dut[0].u_bus.comp_valid), 32'd0);
    step(1);
    check_eq("valid_clk3", 32'(g_dut[0].u_bus.comp_valid), 32'd1);

    // NCO wrap on table 6.
    phase_inc = 24'h100000; chroma_phase = 8'hF0; chroma_amp = 3'd7; phase_reset = 1'b1;
    step(1);
    phase_reset = 1'b0;
    step(1);
    check_eq("nco_f0", 32'(g_dut[0].u_bus.rom_addr), 32'h6F0);
    step(1);
    check_eq("nco_00", 32'(g_dut[0].u_bus.rom_addr), 32'h600);
    step(1);
    check_eq("nco_10", 32'(g_dut[0].u_bus.rom_addr), 32'h610);
    step(1);
    check_eq("nco_20", 32'(g_dut[0].u_bus.rom_addr), 32'h620);
    phase_reset = 1'b1;
    step(1);
    check_eq("nco_prst_cyc", 32'(g_dut[0].u_bus.rom_addr), 32'h630);
    phase_reset = 1'b0;
    step(1);
    check_eq("nco_restart", 32'(g_dut[0].u_bus.rom_addr), 32'h6F0);
    step(1);
    check_eq("nco_after", 32'(g_dut[0].u_bus.rom_addr), 32'h600);

    // Frozen phase, then burst override and its release.
    phase_inc = 24'd0;
    step(1);
    check_eq("frozen_a", 32'(g_dut[0].u_bus.rom_addr), 32'h610);
    step(3);
    check_eq("frozen_b", 32'(g_dut[0].u_bus.rom_addr), 32'h610);
    burst = 1'b1; burst_phase = 8'h40; burst_amp = 3'd3;
    step(1);
    check_eq("burst_addr", 32'(g_dut[0].u_bus.rom_addr), 32'h260);
    burst = 1'b0;
    step(1);
    check_eq("burst_off", 32'(g_dut[0].u_bus.rom_addr), 32'h610);

    // Mixer alignment with acc held at 0.
    phase_reset = 1'b1;
    step(1);
    phase_reset = 1'b0; luma = 6'd10; chroma_amp = 3'd1; chroma_phase = 8'h30;
    step(4);
    check_eq("mix_addr", 32'(g_dut[0].u_bus.rom_addr), 32'h030);
    check_eq("mix_a",    32'(g_dut[0].u_bus.comp_out), 32'd128);
    chroma_phase = 8'hC0;
    step(2);
    check_eq("mix_hold", 32'(g_dut[0].u_bus.comp_out), 32'd128);
    step(1);
    check_eq("mix_b",    32'(g_dut[0].u_bus.comp_out), 32'd272);

    chroma_amp = 3'd0;
    step(4);
    check_eq("amp0_addr", 32'(g_dut[0].u_bus.rom_addr), 32'h0C0);
    check_eq("amp0_out",  32'(g_dut[0].u_bus.comp_out), 32'd208);
    chroma_amp = 3'd1; sync = 1'b1;
    step(4);
    check_eq("sync_out", 32'(g_dut[0].u_bus.comp_out), 32'd0);
    sync = 1'b0;

    // Burst on the back porch: chroma survives blank.
    blank = 1'b1; burst = 1'b1; burst_phase = 8'h40; burst_amp = 3'd3;
    step(4);
    check_eq("porch_addr", 32'(g_dut[0].u_bus.rom_addr), 32'h240);
    check_eq("porch_out",  32'(g_dut[0].u_bus.comp_out), 32'd64);

    // Clamp and range.
    blank = 1'b0; burst = 1'b0; luma = 6'd63; chroma_amp = 3'd1;
    rom_mode = 1'b1; rom_const = 9'd511;
    step(4);
    check_eq("clamp_887",  32'(g_dut[0].u_bus.comp_out), 32'd887);
    check_eq("clamp_bl0",  32'(g_dut[1].u_bus.comp_out), 32'd759);
    check_eq("clamp_1023", 32'(g_dut[2].u_bus.comp_out), 32'd1023);
    blank = 1'b1; rom_const = 9'd0; chroma_amp = 3'd7; chroma_phase = 8'h00;
    step(4);
    check_eq("under_bl0",  32'(g_dut[1].u_bus.comp_out), 32'd0);
    check_eq("under_bl128", 32'(g_dut[0].u_bus.comp_out), 32'd0);
    check_eq("under_bl600", 32'(g_dut[2].u_bus.comp_out), 32'd344);
    check_eq("under_addr", 32'(g_dut[0].u_bus.rom_addr), 32'h600);

    // Mid-stream asynchronous reset.
    rst_n = 1'b0;
    #1;
    check_eq("mrst_addr",  32'(g_dut[0].u_bus.rom_addr),   32'h000);
    check_eq("mrst_out",   32'(g_dut[2].u_bus.comp_out),   32'd0);
    check_eq("mrst_valid", 32'(g_dut[2].u_bus.comp_valid), 32'd0);
    step(2);
    check_eq("mrst_hold", 32'(g_dut[2].u_bus.comp_out), 32'd0);
    rst_n = 1'b1;
    step(2);
    check_eq("mrst_v2", 32'(g_dut[2].u_bus.comp_valid), 32'd0);
    step(1);
    check_eq("mrst_v3", 32'(g_dut[2].u_bus.comp_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
